// File: rtl/norm_shift_ctrl.sv
// Handshaked right-shift normaliser: shifts an IN_W word down until it is below 2^(OUT_W-1).
// Define NORM_SHIFT_ROUND_EN to round the result by the last bit shifted out (saturating).
module norm_shift_ctrl #(
    parameter int  IN_W  = 32,
    parameter int  OUT_W = 16,
    parameter int  IDX_W = 4,
    localparam int SH_W  = $clog2(IN_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [IN_W-1:0]   data_i,
    input  logic [IDX_W-1:0]  index_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [OUT_W-1:0]  y_o,
    output logic [SH_W-1:0]   shift_o,
    output logic              bit_o
);

    localparam int              YI_W = $clog2(OUT_W);
    localparam logic [OUT_W-1:0] TH_V = OUT_W'(1) << (OUT_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    work_q, work_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SH_W-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic [SH_W-1:0]    shift_q, shift_d;
    logic               bit_q, bit_d;
    logic [OUT_W-1:0]   y_next;
    logic               bit_next;
    logic [IDX_W:0]     pos;
    logic [YI_W-1:0]    sel;
    logic               in_range;
    logic               load;

`ifdef NORM_SHIFT_ROUND_EN
    logic               last_q, last_d;
    logic [OUT_W-1:0]   rnd;
`endif

    // Everything above the top OUT_W-1 bits must be clear to be below TH.
    assign in_range = (work_q[IN_W-1:OUT_W-1] == '0);

    always_comb begin
`ifdef NORM_SHIFT_ROUND_EN
        // work < TH here, so the sum can reach TH at most: its MSB flags saturation.
        rnd    = work_q[OUT_W-1:0] + OUT_W'(last_q);
        y_next = rnd[OUT_W-1] ? (TH_V - OUT_W'(1)) : rnd;
`else
        y_next = work_q[OUT_W-1:0];
`endif
        pos = {idx_q, 1'b1};
        if (int'(pos) <= OUT_W - 2) sel = YI_W'(pos);
        else                        sel = YI_W'(OUT_W - 2);
        bit_next = y_next[sel];
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        load    = 1'b0;
`ifdef NORM_SHIFT_ROUND_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: load = start_i;
            SHIFT: begin
                if (in_range) begin
                    state_d = DONE;
                    y_d     = y_next;
                    shift_d = cnt_q;
                    bit_d   = bit_next;
                end else begin
                    work_d = work_q >> 1;
                    cnt_d  = cnt_q + SH_W'(1);
`ifdef NORM_SHIFT_ROUND_EN
                    last_d = work_q[0];
`endif
                end
            end
            DONE: begin
                load    = start_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = SHIFT;
            work_d  = data_i;
            idx_d   = index_i;
            cnt_d   = '0;
`ifdef NORM_SHIFT_ROUND_EN
            last_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            shift_q <= '0;
            bit_q   <= 1'b0;
`ifdef NORM_SHIFT_ROUND_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
`ifdef NORM_SHIFT_ROUND_EN
            last_q  <= last_d;
`endif
        end
    end

    assign busy_o  = (state_q == SHIFT);
    assign done_o  = (state_q == DONE);
    assign y_o     = y_q;
    assign shift_o = shift_q;
    assign bit_o   = bit_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Randomised and directed bench for norm_shift_ctrl against an arithmetic reference model.
module tb_norm_shift_ctrl;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int IDX_W = 4;
    localparam int SH_W  = $clog2(IN_W) + 1;

    logic              clk = 1'b0;
    logic              rst_i, start_i;
    logic [IN_W-1:0]   data_i;
    logic [IDX_W-1:0]  index_i;
    logic              busy_o, done_o, bit_o;
    logic [OUT_W-1:0]  y_o;
    logic [SH_W-1:0]   shift_o;

    int n_chk = 0;
    int n_pass = 0;

    norm_shift_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .data_i(data_i), .index_i(index_i),
        .busy_o(busy_o), .done_o(done_o), .y_o(y_o), .shift_o(shift_o), .bit_o(bit_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: repeated halving until below 2^(OUT_W-1), then optional rounding.
    function automatic void model_norm(input logic [31:0] d, input logic [3:0] ix,
                                       output logic [15:0] y, output int k, output logic b);
        longint unsigned v;
        longint unsigned last;
        int p;
        v = d; last = 0; k = 0;
        while (v >= 32768) begin
            last = v % 2;
            v = v / 2;
            k++;
        end
`ifdef NORM_SHIFT_ROUND_EN
        v = v + last;
        if (v > 32767) v = 32767;
`endif
        y = 16'(v);
        p = 2 * int'(ix) + 1;
        if (p > 14) p = 14;
        b = y[p];
    endfunction

    // Model timeline: edge count, pending operation and the edge that enters DONE.
    int          ecount = 0;
    bit          pending = 0;
    int          done_edge = 0;
    logic [15:0] op_y, exp_y;
    int          op_k;
    logic        op_b, exp_b;
    logic [5:0]  exp_sh;
    bit          chk_en = 0;

    always @(posedge clk) begin
        ecount = ecount + 1;
        if (rst_i) begin
            pending = 0;
            exp_y = '0; exp_sh = '0; exp_b = 1'b0;
        end else begin
            if (pending && ecount == done_edge) begin
                exp_y = op_y; exp_sh = 6'(op_k); exp_b = op_b;
            end
            if ((!pending || ecount > done_edge) && start_i) begin
                model_norm(data_i, index_i, op_y, op_k, op_b);
                pending = 1;
                done_edge = ecount + 1 + op_k;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("done_o", 32'(done_o), 32'(pending && ecount == done_edge));
            chk("busy_o", 32'(busy_o), 32'(pending && ecount < done_edge));
            chk("y_o", 32'(y_o), 32'(exp_y));
            chk("shift_o", 32'(shift_o), 32'(exp_sh));
            chk("bit_o", 32'(bit_o), 32'(exp_b));
        end
    end

    // Directed op: checks latency and results against literals.
    task automatic run_op(input logic [31:0] d, input logic [3:0] ix, input bit pulse,
                          input int exp_n, input logic [15:0] ey, input int ek, input logic eb);
        int n;
        @(negedge clk);
        start_i = 1'b1; data_i = d; index_i = ix;
        @(negedge clk);
        start_i = 1'b0; data_i = $urandom; index_i = 4'($urandom);
        if (pulse) begin
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            n = 1;
        end else n = 0;
        while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(exp_n));
        chk("dir_y", 32'(y_o), 32'(ey));
        chk("dir_shift", 32'(shift_o), 32'(ek));
        chk("dir_bit", 32'(bit_o), 32'(eb));
    endtask

    initial begin
        logic [15:0] my;
        int mk;
        logic mb;
        rst_i = 1'b1; start_i = 1'b0; data_i = '0; index_i = '0;

        // Pin the model itself.
        model_norm(32'h0001_2345, 4'd3, my, mk, mb);
        chk("model_mid_y", 32'(my), 32'h48D1);
        chk("model_mid_k", 32'(mk), 2);
        model_norm(32'hFFFF_FFFF, 4'd0, my, mk, mb);
        chk("model_max_y", 32'(my), 32'h7FFF);
        chk("model_max_k", 32'(mk), 17);

        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        chk_en = 1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_y", 32'(y_o), 0);
        chk("rst_shift", 32'(shift_o), 0);

        run_op(32'h0001_2345, 4'd3, 0, 3, 16'h48D1, 2, 1'b1);
        run_op(32'h0000_7FFF, 4'd7, 0, 1, 16'h7FFF, 0, 1'b1);
        run_op(32'hFFFF_FFFF, 4'd2, 0, 18, 16'h7FFF, 17, 1'b1);
        run_op(32'h0000_0000, 4'd5, 0, 1, 16'h0000, 0, 1'b0);
        run_op(32'h0001_2345, 4'd3, 1, 3, 16'h48D1, 2, 1'b1);

        // Reset mid-operation: no done_o for the aborted request.
        @(negedge clk);
        start_i = 1'b1; data_i = 32'hFFFF_FFFF; index_i = 4'd1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_y", 32'(y_o), 0);
        repeat (20) @(negedge clk);

        // start_i held high: back-to-back acceptance.
        for (int i = 0; i < 300; i++) begin
            start_i = 1'b1;
            data_i = $urandom >> $urandom_range(0, 31);
            index_i = 4'($urandom);
            @(negedge clk);
        end

        // Fully random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start_i = ($urandom_range(0, 3) == 0);
            data_i = $urandom >> $urandom_range(0, 31);
            index_i = 4'($urandom);
            rst_i = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst_i = 1'b0; start_i = 1'b0;
        repeat (25) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
